mac_array: RTL and testbench
============================

# mac_array

Parametrised broadcast multiply-accumulate array for the MNIST inference datapath; generalises the fixed 32-lane stage-1 array to any lane count and data width. One image sample per cycle is broadcast to all lanes and multiplied by a per-lane weight. The product is accumulated at full precision over a frame delimited by `start`/`stop`. The block adds input-valid qualification, a pipelined datapath, a frame state machine, a sample counter, and output saturation with optional ReLU. It sits between the picoRV32-fed image/weight buffers and the next network stage.

## Interface
- `LANES`, 32, number of parallel MAC lanes
- `DW`, 32, signed two's-complement width of image and weight words
- `AW`, 64, signed accumulator width (≥ 2*DW)
- `OW`, 32, signed output width after saturation
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  begin new frame; clears accumulators and counter
- `stop`  in  1  end current frame
- `in_valid`  in  1  `image` qualifier
- `relu_en`  in  1  clamp negative results to 0; sampled on `start`
- `image`  in  DW  broadcast image sample
- `w`  in  LANES*DW  weights; lane i at bits [i*DW +: DW], sampled with `image`
- `p`  out  LANES*OW  results; lane i at [i*OW +: OW]
- `out_valid`  out  1  one-cycle pulse when `p` is updated
- `busy`  out  1  frame in progress (state ACC or DRAIN)
- `count`  out  16  samples accepted in current/last frame

## Operation
- States:
  - IDLE: reset state.
  - ACC: accepting samples.
  - DRAIN: 3 cycles; pipeline flush.
  - DONE: 1 cycle; `out_valid`=1, then IDLE.
- `start` in any state: go to ACC. Zero all accumulators and `count`. Latch `relu_en`. Kill in-flight pipeline stages 2–3.
- `start` in ACC/DRAIN aborts the current frame; no `out_valid` is produced for the aborted frame.
- Sample accepted when `in_valid`=1 and (state==ACC or `start`=1). A sample in the `start` cycle is the first sample of the new frame.
- `stop` is honoured only in ACC, or together with `start` (gives a one-sample or empty frame). A sample in the `stop` cycle is included. After `stop`: DRAIN.
- `stop` in IDLE/DRAIN/DONE: ignored. `in_valid` outside ACC (without `start`): ignored.
- Pipeline:
  - S1 registers `image`, `w`, valid.
  - S2 registers signed products (2*DW bits).
  - S3 accumulates products sign-extended to AW. Accumulator wraps modulo 2^AW.
- DONE: per lane, if `relu_en` was latched and acc<0, result = 0. Otherwise saturate to the signed OW range. `p` is registered, then held until the next DONE.
- `count` increments per accepted sample and saturates at 65535. It holds after DONE until the next `start`.
- Reset values: state IDLE, `p`=0, `out_valid`=0, `busy`=0, `count`=0, accumulators 0, all valid bits 0.
- `rst` mid-frame discards everything; no `out_valid`.

## Timing
- Sample at cycle t reaches the accumulator at the edge ending cycle t+2.
- `stop` sampled at cycle s: DRAIN in s+1..s+3, DONE in s+4. `out_valid`=1 and new `p` are visible in cycle s+4.
- `start` at cycle T: `busy`=1 from T+1. `busy`=0 in the DONE cycle.
- `start`+`stop` in the same cycle: frame of 0 or 1 sample; `out_valid` at T+4.
- Throughput: one sample per cycle. Back-to-back frames: `start` may be asserted in the DONE cycle.

## Structure
- Package `mac_array_pkg`:
  - state enum (IDLE, ACC, DRAIN, DONE);
  - DRAIN_CYCLES=3, COUNT_W=16;
  - saturate/ReLU function parametrised by AW/OW.
- Sub-module `mac_lane`, generated LANES times, holds the S2 product register, S3 accumulator and output saturation/ReLU.
- The top holds the FSM, counter, shared S1 image register, S1 per-lane weight registers and valid pipeline.

## Test plan
- Basic: lane i weight = i; samples 1, 2, 3 in consecutive cycles, then `stop`. Expect `p[i]`=6i, `count`=3, `out_valid` 4 cycles after `stop`, exactly one pulse.
- Gapped valid: samples 5, 7 with 2 idle cycles between, w=-3 all lanes, `relu_en`=0. Expect `p`=-36 (0xFFFFFFDC), `count`=2. Same run with `relu_en`=1: expect `p`=0.
- Saturation: w=image=0x7FFFFFFF for 2 samples. Expect `p`=0x7FFFFFFF. Same with w=0x80000001: expect `p`=0x80000000.
- Abort: `start`, 4 samples of 1 (w=1), `start` again with sample 9 in the same cycle, 1 more sample of 1, `stop`. Expect `p`=10, `count`=2, a single `out_valid`.
- Edge cases:
  - `start`+`stop`+`in_valid` in one cycle, sample 4, w=2: expect `p`=8, `count`=1.
  - `stop`/`in_valid` in IDLE: no effect.
- Reset: assert `rst` in DRAIN. Expect no `out_valid` and all outputs 0 the cycle after `rst`; the next frame is computed correctly.

Source files
------------

// File: rtl/mac_array_pkg.sv
// Shared types, constants and the output saturation/ReLU helper for the
// broadcast multiply-accumulate array.
package mac_array_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DRAIN_CYCLES = 3;
   localparam int COUNT_W      = 16;
   // Widest accumulator the helper supports; callers sign-extend into it.
   localparam int SAT_W        = 128;

   function automatic logic signed [SAT_W-1:0] sat_relu(
      input logic signed [SAT_W-1:0] acc,
      input int                      ow,
      input logic                    relu
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) << (ow - 1)) - SAT_W'(1);
      lo = ~hi;
      if (relu && acc[SAT_W-1]) return '0;
      if (acc > hi)             return hi;
      if (acc < lo)             return lo;
      return acc;
   endfunction

endpackage

// File: rtl/mac_array_if.sv
// Frame control, sample/weight bus and result bus of the MAC array.
interface mac_array_if
   import mac_array_pkg::*;
#(
   parameter int LANES = 32,
   parameter int DW    = 32,
   parameter int OW    = 32
);
   logic                  start;
   logic                  stop;
   logic                  in_valid;
   logic                  relu_en;
   logic [DW-1:0]         image;
   logic [LANES*DW-1:0]   w;
   logic [LANES*OW-1:0]   p;
   logic                  out_valid;
   logic                  busy;
   logic [COUNT_W-1:0]    count;

   modport master (
      output start, stop, in_valid, relu_en, image, w,
      input  p, out_valid, busy, count
   );

   modport slave (
      input  start, stop, in_valid, relu_en, image, w,
      output p, out_valid, busy, count
   );
endinterface

// File: rtl/mac_array_lane.sv
// One MAC lane: S2 product register, S3 full-precision accumulator and the
// saturated/ReLU result register.
module mac_lane
   import mac_array_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 64,
   parameter int OW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 s2_valid,
   input  logic                 load,
   input  logic                 relu,
   input  logic signed [DW-1:0] img,
   input  logic signed [DW-1:0] wt,
   output logic [OW-1:0]        p
);
   logic signed [2*DW-1:0] prod_reg;
   logic signed [AW-1:0]   acc_reg;
   logic [OW-1:0]          p_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_reg <= '0;
         acc_reg  <= '0;
         p_reg    <= '0;
      end else begin
         prod_reg <= img * wt;
         // start discards whatever product is in flight for the old frame
         if (clr)
            acc_reg <= '0;
         else if (s2_valid)
            acc_reg <= acc_reg + AW'(prod_reg);
         if (load)
            p_reg <= OW'(sat_relu(SAT_W'(acc_reg), OW, relu));
      end
   end

   assign p = p_reg;
endmodule

// File: rtl/mac_array.sv
// Broadcast MAC array top: frame FSM, sample counter, shared S1 registers and
// valid pipeline feeding LANES accumulate lanes.
module mac_array
   import mac_array_pkg::*;
#(
   parameter int LANES = 32,
   parameter int DW    = 32,
   parameter int AW    = 64,
   parameter int OW    = 32
) (
   input  logic      clk,
   input  logic      rst,
   mac_array_if.slave bus
);
   localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

   state_t               state_reg, state_next;
   logic [1:0]           drain_reg, drain_next;
   logic [COUNT_W-1:0]   count_reg;
   logic                 relu_reg;
   logic                 s1_valid_reg, s2_valid_reg;
   logic signed [DW-1:0] image_reg;
   logic                 accept;
   logic                 load;
   logic [LANES*OW-1:0]  p_all;

   assign accept = bus.in_valid && ((state_reg == ACC) || bus.start);

   always_comb begin
      state_next = state_reg;
      drain_next = drain_reg;
      load       = 1'b0;
      case (state_reg)
         ACC: begin
            if (bus.stop) begin
               state_next = DRAIN;
               drain_next = '0;
            end
         end
         DRAIN: begin
            if (drain_reg == DRAIN_LAST) begin
               state_next = DONE;
               load       = 1'b1;
            end else begin
               drain_next = drain_reg + 2'd1;
            end
         end
         DONE:    state_next = IDLE;
         default: ;
      endcase
      // start overrides everything, including a frame that is about to finish
      if (bus.start) begin
         state_next = bus.stop ? DRAIN : ACC;
         drain_next = '0;
         load       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         drain_reg    <= '0;
         count_reg    <= '0;
         relu_reg     <= 1'b0;
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         image_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         drain_reg    <= drain_next;
         s1_valid_reg <= accept;
         s2_valid_reg <= s1_valid_reg && !bus.start;
         if (accept)
            image_reg <= bus.image;
         if (bus.start) begin
            relu_reg  <= bus.relu_en;
            count_reg <= COUNT_W'(accept);
         end else if (accept && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic signed [DW-1:0] w_s1_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               w_s1_reg <= '0;
            else if (accept)
               w_s1_reg <= bus.w[gi*DW +: DW];
         end

         mac_lane #(.DW(DW), .AW(AW), .OW(OW)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (bus.start),
            .s2_valid (s2_valid_reg),
            .load     (load),
            .relu     (relu_reg),
            .img      (image_reg),
            .wt       (w_s1_reg),
            .p        (p_all[gi*OW +: OW])
         );
      end
   endgenerate

   assign bus.p         = p_all;
   assign bus.out_valid = (state_reg == DONE);
   assign bus.busy      = (state_reg == ACC) || (state_reg == DRAIN);
   assign bus.count     = count_reg;
endmodule

// File: tb/tb_mac_array.sv
// Bench for mac_array: table-driven frames plus hand-written abort, edge and
// reset sequences; results checked by a scoreboard on out_valid.
module tb_mac_array;
   import mac_array_pkg::*;

   localparam int LANES = 4;
   localparam int DW    = 32;
   localparam int AW    = 64;
   localparam int OW    = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mac_array_if #(.LANES(LANES), .DW(DW), .OW(OW)) bus ();

   mac_array #(.LANES(LANES), .DW(DW), .AW(AW), .OW(OW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      int          n;
      logic [31:0] samp [4];
      int          gap;
      bit          by_lane;
      logic [31:0] wv;
      bit          relu;
      logic [31:0] unit;
      int          cnt;
   } vec_t;

   typedef struct {
      logic [LANES-1:0][OW-1:0] p;
      int                       count;
      int                       at;
   } exp_t;

   vec_t vecs [5];
   exp_t sb [$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // scoreboard consumer
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL spurious out_valid at cycle %0d: got 1, expected 0", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("out_valid cycle", 64'(cyc), 64'(mon_e.at));
            for (int i = 0; i < LANES; i++)
               check($sformatf("p lane%0d", i), 64'(bus.p[i*OW +: OW]), 64'(mon_e.p[i]));
            check("count", 64'(bus.count), 64'(mon_e.count));
            $display("frame done cycle %0d: p0=0x%0h p%0d=0x%0h count=%0d",
                     cyc, bus.p[OW-1:0], LANES-1, bus.p[(LANES-1)*OW +: OW], bus.count);
         end
      end
   end

   task automatic drive(input bit st, input bit sp, input bit v, input logic [DW-1:0] img);
      bus.start    = st;
      bus.stop     = sp;
      bus.in_valid = v;
      bus.image    = img;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.in_valid = 1'b0;
      bus.image    = '0;
   endtask

   task automatic set_w(input bit by_lane, input logic [DW-1:0] wv);
      for (int i = 0; i < LANES; i++)
         bus.w[i*DW +: DW] = by_lane ? DW'(i) : wv;
   endtask

   task automatic push_exp(input logic [OW-1:0] unit, input bit by_lane, input int cnt, input int at);
      exp_t e;
      for (int i = 0; i < LANES; i++)
         e.p[i] = by_lane ? unit * OW'(i) : unit;
      e.count = cnt;
      e.at    = at;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      n_total++;
      if (sb.size() == 0) n_pass++;
      else begin
         $display("FAIL %s timeout: %0d results outstanding, expected 0", name, sb.size());
         sb.delete();
      end
      repeat (3) drive(0, 0, 0, '0);
   endtask

   task automatic run_vec(input vec_t v);
      set_w(v.by_lane, v.wv);
      bus.relu_en = v.relu;
      drive(1, 0, 0, '0);
      bus.relu_en = 1'b0;
      check({v.name, " busy"}, 64'(bus.busy), 64'd1);
      for (int k = 0; k < v.n; k++) begin
         drive(0, 0, 1, v.samp[k]);
         if (k < v.n - 1)
            repeat (v.gap) drive(0, 0, 0, '0);
      end
      push_exp(v.unit, v.by_lane, v.cnt, cyc + 4);
      drive(0, 1, 0, '0);
      wait_drain(v.name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{name:"basic", n:3, samp:'{32'd1, 32'd2, 32'd3, 32'd0}, gap:0, by_lane:1'b1,
                  wv:32'd0, relu:1'b0, unit:32'd6, cnt:3};
      vecs[1] = '{name:"gapped", n:2, samp:'{32'd5, 32'd7, 32'd0, 32'd0}, gap:2, by_lane:1'b0,
                  wv:32'hFFFF_FFFD, relu:1'b0, unit:32'hFFFF_FFDC, cnt:2};
      vecs[2] = '{name:"gapped relu", n:2, samp:'{32'd5, 32'd7, 32'd0, 32'd0}, gap:2, by_lane:1'b0,
                  wv:32'hFFFF_FFFD, relu:1'b1, unit:32'd0, cnt:2};
      vecs[3] = '{name:"sat pos", n:2, samp:'{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0}, gap:0,
                  by_lane:1'b0, wv:32'h7FFF_FFFF, relu:1'b0, unit:32'h7FFF_FFFF, cnt:2};
      vecs[4] = '{name:"sat neg", n:2, samp:'{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0}, gap:0,
                  by_lane:1'b0, wv:32'h8000_0001, relu:1'b0, unit:32'h8000_0000, cnt:2};

      bus.start = 0; bus.stop = 0; bus.in_valid = 0; bus.relu_en = 0;
      bus.image = '0; bus.w = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < LANES; i++)
         check($sformatf("reset p lane%0d", i), 64'(bus.p[i*OW +: OW]), 64'd0);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset count", 64'(bus.count), 64'd0);

      // stop and samples in IDLE must not start anything
      set_w(0, 32'd1);
      drive(0, 1, 1, 32'd5);
      drive(0, 0, 1, 32'd6);
      repeat (5) drive(0, 0, 0, '0);
      check("idle count", 64'(bus.count), 64'd0);
      check("idle busy", 64'(bus.busy), 64'd0);

      for (int v = 0; v < 5; v++)
         run_vec(vecs[v]);

      // abort: the restart cycle carries the first sample of the new frame
      set_w(0, 32'd1);
      drive(1, 0, 0, '0);
      repeat (4) drive(0, 0, 1, 32'd1);
      drive(1, 0, 1, 32'd9);
      drive(0, 0, 1, 32'd1);
      push_exp(32'd10, 0, 2, cyc + 4);
      drive(0, 1, 0, '0);
      wait_drain("abort");

      // start+stop+sample in a single cycle
      set_w(0, 32'd2);
      push_exp(32'd8, 0, 1, cyc + 4);
      drive(1, 1, 1, 32'd4);
      wait_drain("one sample");

      drive(0, 1, 1, 32'd3);
      repeat (5) drive(0, 0, 0, '0);
      check("count held after done", 64'(bus.count), 64'd1);
      check("stop in idle busy", 64'(bus.busy), 64'd0);

      // reset during DRAIN drops the frame
      set_w(1, '0);
      drive(1, 0, 0, '0);
      drive(0, 0, 1, 32'd1);
      drive(0, 0, 1, 32'd2);
      drive(0, 0, 1, 32'd3);
      drive(0, 1, 0, '0);
      drive(0, 0, 0, '0);
      rst = 1'b1;
      #1;
      for (int i = 0; i < LANES; i++)
         check($sformatf("rst p lane%0d", i), 64'(bus.p[i*OW +: OW]), 64'd0);
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst count", 64'(bus.count), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) drive(0, 0, 0, '0);
      run_vec(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
